// File: rtl/dram_line_bridge_pkg.sv
// Shared types for the DRAM line bridge: FSM state encoding and line geometry.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dram_line_bridge_pkg;

    localparam int LINE_BITS  = 128;
    localparam int LINE_BYTES = 16;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_ISSUE        = 3'd1,
        ST_WAIT_ACK     = 3'd2,
        ST_WAIT_DONE    = 3'd3,
        ST_DONE         = 3'd4,
        ST_RF_ISSUE     = 3'd5,
        ST_RF_WAIT_ACK  = 3'd6,
        ST_RF_WAIT_DONE = 3'd7
    } state_t;

endpackage

// File: rtl/dram_refresh_timer.sv
// Free-running refresh interval counter with a sticky "refresh due" flag.
// Latency: due rises combinationally on the wrap cycle, then stays set until clr.
// Backpressure: a wrap while already pending is absorbed (never queued twice).
//
// Ports: clk, rst_x (async active-low), clr (refresh completed), due (refresh owed).
module dram_refresh_timer #(
    parameter int CYCLES = 780
) (
    input  logic clk,
    input  logic rst_x,
    input  logic clr,
    output logic due
);

    localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic [CW-1:0] cnt_q;
    logic          pending_q;
    logic          wrap;

    assign wrap = (cnt_q == CW'(CYCLES - 1));
    // The wrap cycle already counts as due, so a request arriving on that
    // very cycle loses to the refresh.
    assign due  = pending_q | wrap;

    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            cnt_q     <= '0;
            pending_q <= 1'b0;
        end else begin
            cnt_q <= wrap ? '0 : cnt_q + CW'(1);
            // A fresh wrap beats a simultaneous clear: that is a new interval.
            if (wrap)
                pending_q <= 1'b1;
            else if (clr)
                pending_q <= 1'b0;
        end
    end

endmodule

// File: rtl/dram_line_bridge.sv
// Splits 128-bit line reads/writes into BEATS sequential word commands on a narrow SDRAM port.
// Latency: read = BEATS x (issue + ack + done) + 2 cycles; fully masked write beats cost 1 cycle.
// Backpressure: commands wait for m_busy low; o_busy high while a line or refresh is in flight.
//
// Ports: clk / rst_x (async active-low); upstream i_rd_en, i_wr_en, i_addr, i_data, i_mask,
//        o_data, o_busy, o_init_calib_complete; downstream m_rd, m_wr, m_refresh, m_addr,
//        m_din, m_wmask, m_dout, m_busy, m_init_done.
// Build option: DRAM_BRIDGE_REFRESH_EN enables scheduled auto-refresh between lines.
module dram_line_bridge
    import dram_line_bridge_pkg::*;
#(
    parameter int DW             = 16,
    parameter int AW             = 22,
    parameter int REFRESH_CYCLES = 780
) (
    input  logic              clk,
    input  logic              rst_x,
    input  logic              i_rd_en,
    input  logic              i_wr_en,
    input  logic [31:0]       i_addr,
    input  logic [127:0]      i_data,
    input  logic [15:0]       i_mask,
    output logic [127:0]      o_data,
    output logic              o_busy,
    output logic              o_init_calib_complete,
    output logic              m_rd,
    output logic              m_wr,
    output logic              m_refresh,
    output logic [AW-1:0]     m_addr,
    output logic [DW-1:0]     m_din,
    output logic [DW/8-1:0]   m_wmask,
    input  logic [DW-1:0]     m_dout,
    input  logic              m_busy,
    input  logic              m_init_done
);

    localparam int BEATS = LINE_BITS / DW;
    localparam int BB    = $clog2(BEATS);
    localparam int MB    = DW / 8;
    localparam int LB    = $clog2(MB);
    localparam int DWL   = $clog2(DW);
    localparam int AHI   = AW + LB - 1;   // top byte-address bit that reaches m_addr
    localparam int RW    = AW - BB;       // line-address bits kept in the request latch

    state_t          state_q, state_d;
    logic [BB-1:0]   beat_q;
    logic            is_rd_q;
    logic [RW-1:0]   addr_q;
    logic [127:0]    line_q;
    logic [15:0]     mask_q;
    logic [127:0]    shadow_q;

    logic [6:0]      bit_base;
    logic [3:0]      byte_base;
    logic [MB-1:0]   beat_mask;
    logic            beat_skip;
    logic            last_beat;
    logic            refresh_due;
    logic            refresh_clr;

    logic            take_req;
    logic            take_rf;
    logic            issue_fire;
    logic            rf_fire;
    logic            beat_done;
    logic            beat_adv;
    logic            line_done;

    logic            unused_addr_bits;
    assign unused_addr_bits = ^{i_addr[31:AHI+1], i_addr[3:0]};

    // beat * DW and beat * MB without a multiplier: the beat index is the
    // upper bits of a 7-bit line bit offset.
    assign bit_base  = {beat_q, {DWL{1'b0}}};
    assign byte_base = bit_base[6:3];
    assign beat_mask = mask_q[byte_base +: MB];
    assign beat_skip = !is_rd_q && (&beat_mask);
    assign last_beat = (beat_q == BB'(BEATS - 1));

    // Downstream address/data come straight from the latched request and beat,
    // so they stay put from the command pulse until the beat completes.
    assign m_addr  = {addr_q, beat_q};
    assign m_din   = line_q[bit_base +: DW];
    assign m_wmask = beat_mask;

    assign o_init_calib_complete = m_init_done;
    assign refresh_clr           = (state_q == ST_RF_WAIT_DONE) && !m_busy;

`ifdef DRAM_BRIDGE_REFRESH_EN
    dram_refresh_timer #(
        .CYCLES (REFRESH_CYCLES)
    ) u_refresh_timer (
        .clk   (clk),
        .rst_x (rst_x),
        .clr   (refresh_clr),
        .due   (refresh_due)
    );
`else
    logic unused_refresh_cfg;
    assign unused_refresh_cfg = (REFRESH_CYCLES != 0) ^ refresh_clr;
    assign refresh_due        = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (m_init_done) begin
                    if (refresh_due)
                        state_d = ST_RF_ISSUE;
                    else if (i_rd_en || i_wr_en)
                        state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (beat_skip)
                    state_d = last_beat ? ST_DONE : ST_ISSUE;
                else if (!m_busy)
                    state_d = ST_WAIT_ACK;
            end
            ST_WAIT_ACK:     if (m_busy)  state_d = ST_WAIT_DONE;
            ST_WAIT_DONE:    if (!m_busy) state_d = last_beat ? ST_DONE : ST_ISSUE;
            ST_DONE:         state_d = ST_IDLE;
            ST_RF_ISSUE:     if (!m_busy) state_d = ST_RF_WAIT_ACK;
            ST_RF_WAIT_ACK:  if (m_busy)  state_d = ST_RF_WAIT_DONE;
            ST_RF_WAIT_DONE: if (!m_busy) state_d = ST_IDLE;
            default:         state_d = ST_IDLE;
        endcase
    end

    // Per-state strobes driving the datapath.
    always_comb begin
        take_req   = 1'b0;
        take_rf    = 1'b0;
        issue_fire = 1'b0;
        rf_fire    = 1'b0;
        beat_done  = 1'b0;
        beat_adv   = 1'b0;
        line_done  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                take_rf  = m_init_done && refresh_due;
                take_req = m_init_done && !refresh_due && (i_rd_en || i_wr_en);
            end
            ST_ISSUE: begin
                issue_fire = !beat_skip && !m_busy;
                beat_adv   = beat_skip;
            end
            ST_WAIT_DONE: begin
                beat_done = !m_busy;
                beat_adv  = !m_busy;
            end
            ST_DONE:     line_done = 1'b1;
            ST_RF_ISSUE: rf_fire   = !m_busy;
            default: ;
        endcase
    end

    // Datapath: request latch, beat counter, shadow line and command pulses.
    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            beat_q   <= '0;
            is_rd_q  <= 1'b0;
            addr_q   <= '0;
            line_q   <= '0;
            mask_q   <= '0;
            shadow_q <= '0;
            o_data   <= '0;
            o_busy   <= 1'b0;
            m_rd     <= 1'b0;
            m_wr     <= 1'b0;
        end else begin
            m_rd <= issue_fire && is_rd_q;
            m_wr <= issue_fire && !is_rd_q;

            if (take_req) begin
                is_rd_q <= i_rd_en;   // read wins when both are raised
                addr_q  <= i_addr[AHI:4];
                line_q  <= i_data;
                mask_q  <= i_mask;
                beat_q  <= '0;
                o_busy  <= 1'b1;
            end
            if (take_rf)
                o_busy <= 1'b1;

            if (beat_done && is_rd_q)
                shadow_q[bit_base +: DW] <= m_dout;
            if (beat_adv && !last_beat)
                beat_q <= beat_q + BB'(1);

            if (line_done) begin
                if (is_rd_q)
                    o_data <= shadow_q;
                o_busy <= 1'b0;
            end
            if (refresh_clr)
                o_busy <= 1'b0;
        end
    end

`ifdef DRAM_BRIDGE_REFRESH_EN
    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x)
            m_refresh <= 1'b0;
        else
            m_refresh <= rf_fire;
    end
`else
    logic unused_rf_fire;
    assign unused_rf_fire = rf_fire;
    assign m_refresh      = 1'b0;
`endif

endmodule

// File: tb/tb_dram_line_bridge.sv
// Self-checking bench for dram_line_bridge with a randomized SDRAM word-port model.
// Latency: n/a (bench).
// Backpressure: downstream model inserts random ack/busy delays on every command.
module tb_dram_line_bridge;

    localparam int DW    = 16;
    localparam int AW    = 22;
    localparam int BEATS = 128 / DW;
`ifdef DRAM_BRIDGE_REFRESH_EN
    localparam int RC = 50;
`else
    localparam int RC = 780;
`endif

    logic          clk;
    logic          rst_x;
    logic          i_rd_en, i_wr_en;
    logic [31:0]   i_addr;
    logic [127:0]  i_data;
    logic [15:0]   i_mask;
    logic [127:0]  o_data;
    logic          o_busy, o_init_calib_complete;
    logic          m_rd, m_wr, m_refresh;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_din;
    logic [1:0]    m_wmask;
    logic [DW-1:0] m_dout;
    logic          m_busy, m_init_done;

    dram_line_bridge #(.DW(DW), .AW(AW), .REFRESH_CYCLES(RC)) dut (
        .clk(clk), .rst_x(rst_x), .i_rd_en(i_rd_en), .i_wr_en(i_wr_en),
        .i_addr(i_addr), .i_data(i_data), .i_mask(i_mask), .o_data(o_data),
        .o_busy(o_busy), .o_init_calib_complete(o_init_calib_complete),
        .m_rd(m_rd), .m_wr(m_wr), .m_refresh(m_refresh), .m_addr(m_addr),
        .m_din(m_din), .m_wmask(m_wmask), .m_dout(m_dout), .m_busy(m_busy),
        .m_init_done(m_init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { int op; int addr; int wm; } cmd_t;   // op: 0 rd, 1 wr, 2 refresh

    int           checks   = 0;
    int           failures = 0;
    int           proto_err = 0;
    int           line_cmds = 0;
    int           rf_total  = 0;
    int           last_rf   = 0;
    cmd_t         cmd_q[$];
    logic [15:0]  dmem [int];      // downstream device contents (word addressed)
    logic [7:0]   ref_mem [int];   // reference: byte-addressed line memory
    logic [127:0] exp_odata;

    // Downstream SDRAM word-port model: accepts a one-cycle command, acks after
    // 0..2 cycles, stays busy 1..4 cycles, returns read data as busy falls.
    initial begin
        int ph, cnt, nb;
        logic [15:0] rdata, wv;
        logic [AW-1:0] h_addr;
        logic [15:0] h_din;
        logic [1:0] h_wm;
        logic h_rf;
        cmd_t c;
        m_busy = 1'b0; m_dout = '0; ph = 0; cnt = 0; h_rf = 1'b0;
        h_addr = '0; h_din = '0; h_wm = '0; rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (!rst_x) begin
                m_busy = 1'b0; ph = 0;
            end else begin
                if (ph != 0 && (m_rd || m_wr || m_refresh)) proto_err++;
                if (ph != 0 && !h_rf && (m_addr !== h_addr || m_din !== h_din || m_wmask !== h_wm))
                    proto_err++;
                case (ph)
                    0: if (m_rd || m_wr || m_refresh) begin
                        nb = int'(m_rd) + int'(m_wr) + int'(m_refresh);
                        if (nb > 1) proto_err++;
                        c.op = m_refresh ? 2 : (m_wr ? 1 : 0);
                        c.addr = int'(m_addr);
                        c.wm = int'(m_wmask);
                        cmd_q.push_back(c);
                        if (m_refresh) rf_total++; else line_cmds++;
                        h_addr = m_addr; h_din = m_din; h_wm = m_wmask; h_rf = m_refresh;
                        if (m_wr) begin
                            wv = dmem.exists(int'(m_addr)) ? dmem[int'(m_addr)] : 16'h0;
                            for (int b = 0; b < 2; b++)
                                if (!m_wmask[b]) wv[8*b +: 8] = m_din[8*b +: 8];
                            dmem[int'(m_addr)] = wv;
                        end
                        rdata = dmem.exists(int'(m_addr)) ? dmem[int'(m_addr)] : 16'h0;
                        cnt = $urandom_range(0, 2);
                        ph = 1;
                    end
                    1: if (cnt == 0) begin
                        m_busy = 1'b1; cnt = $urandom_range(0, 3); ph = 2;
                    end else cnt--;
                    default: if (cnt == 0) begin
                        m_busy = 1'b0; m_dout = rdata; ph = 0;
                    end else cnt--;
                endcase
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1);
    end

    function automatic logic [127:0] ref_line(input int base);
        logic [127:0] v;
        for (int b = 0; b < 16; b++)
            v[8*b +: 8] = ref_mem.exists(base + b) ? ref_mem[base + b] : 8'h00;
        return v;
    endfunction

    task automatic wait_idle(input int budget, output bit ok);
        for (int i = 0; o_busy && i < budget; i++) begin
            @(posedge clk); #1;
        end
        ok = !o_busy;
    endtask

    // One upstream line transaction, checked against the reference memory.
    task automatic run_line(input bit rd, input bit wr, input logic [31:0] addr,
                            input logic [127:0] data, input logic [15:0] mask, input string tag);
        cmd_t exp_q[$];
        cmd_t c;
        int base, p0, bad;
        bit ok, taken;
        base = int'(addr) & ~15;
        for (int k = 0; k < BEATS; k++)
            if (rd || mask[2*k +: 2] != 2'b11) begin
                c.op = rd ? 0 : 1; c.addr = (base >> 1) + k;
                c.wm = rd ? -1 : int'(mask[2*k +: 2]);
                exp_q.push_back(c);
            end
        wait_idle(3000, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL %s_idle: o_busy=%0b before start, required 0", tag, o_busy); end
        cmd_q.delete();
        p0 = proto_err;
        i_addr = addr; i_data = data; i_mask = mask; i_rd_en = rd; i_wr_en = wr;
        taken = 1'b0;
        for (int i = 0; i < 400 && !taken; i++) begin
            @(posedge clk); #1;
            if (i == 0) begin
                checks++;
                if (o_busy !== 1'b1) begin failures++; $display("FAIL %s_busy_latency: o_busy=%0b one cycle after request, required 1", tag, o_busy); end
            end
            if (o_busy) begin
                @(posedge clk); #1;
                if (m_refresh) wait_idle(200, ok);   // a refresh went first; keep requesting
                else taken = 1'b1;
            end
        end
        i_rd_en = 1'b0; i_wr_en = 1'b0;
        checks++;
        if (!taken) begin failures++; $display("FAIL %s_taken: request accepted=0, required 1", tag); end
        wait_idle(3000, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL %s_done: o_busy=%0b after budget, required 0", tag, o_busy); end
        if (rd) exp_odata = ref_line(base);
        else for (int b = 0; b < 16; b++) if (!mask[b]) ref_mem[base + b] = data[8*b +: 8];
        checks++;
        if (o_data !== exp_odata) begin failures++; $display("FAIL %s_odata: got %h required %h", tag, o_data, exp_odata); end
        last_rf = 0;
        while (cmd_q.size() > 0 && cmd_q[0].op == 2) begin void'(cmd_q.pop_front()); last_rf++; end
        checks++;
        if (cmd_q.size() != exp_q.size()) begin
            failures++; $display("FAIL %s_cmd_count: got %0d commands, required %0d", tag, cmd_q.size(), exp_q.size());
        end else begin
            bad = -1;
            foreach (exp_q[k])
                if (bad < 0 && (cmd_q[k].op != exp_q[k].op || cmd_q[k].addr != exp_q[k].addr ||
                    (exp_q[k].wm >= 0 && cmd_q[k].wm != exp_q[k].wm))) bad = k;
            if (bad >= 0) begin
                failures++;
                $display("FAIL %s_cmd: #%0d got op=%0d addr=%h wm=%0d, required op=%0d addr=%h wm=%0d", tag, bad,
                         cmd_q[bad].op, cmd_q[bad].addr, cmd_q[bad].wm, exp_q[bad].op, exp_q[bad].addr, exp_q[bad].wm);
            end
        end
        checks++;
        if (proto_err != p0) begin failures++; $display("FAIL %s_protocol: %0d handshake violations, required 0", tag, proto_err - p0); end
    endtask

    task automatic test_reset();
        rst_x = 1'b0; m_init_done = 1'b0; i_rd_en = 1'b1; i_wr_en = 1'b0;
        i_addr = '0; i_data = '0; i_mask = '0; exp_odata = '0;
        repeat (3) @(posedge clk); #1;
        checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b required 0", o_busy); end
        checks++; if (o_data !== 128'h0) begin failures++; $display("FAIL reset_odata: got %h required 0", o_data); end
        checks++; if ({m_rd, m_wr, m_refresh} !== 3'b000) begin failures++; $display("FAIL reset_cmds: got %b required 000", {m_rd, m_wr, m_refresh}); end
        checks++; if ({m_addr, m_din, m_wmask} !== '0) begin failures++; $display("FAIL reset_bus: got addr=%h din=%h wm=%b required 0", m_addr, m_din, m_wmask); end
        rst_x = 1'b1;
    endtask

    task automatic test_init_gate();
        bit bad = 1'b0;
        i_rd_en = 1'b1; i_addr = 32'h0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (o_busy || cmd_q.size() != 0) bad = 1'b1;
        end
        checks++; if (bad) begin failures++; $display("FAIL init_gate: busy=%0b cmds=%0d while uninitialised, required 0/0", o_busy, cmd_q.size()); end
        checks++; if (o_init_calib_complete !== 1'b0) begin failures++; $display("FAIL init_flag_low: got %0b required 0", o_init_calib_complete); end
        m_init_done = 1'b1;
        #1;
        checks++; if (o_init_calib_complete !== 1'b1) begin failures++; $display("FAIL init_flag_high: got %0b required 1", o_init_calib_complete); end
        run_line(1'b1, 1'b0, 32'h0, 128'h0, 16'h0, "init_read");
    endtask

    task automatic test_read_pattern();
        for (int k = 0; k < BEATS; k++) begin
            dmem[32'h80 + k] = 16'h1110 + 16'(k);
            ref_mem[32'h100 + 2*k]     = 8'h10 + 8'(k);
            ref_mem[32'h100 + 2*k + 1] = 8'h11;
        end
        run_line(1'b1, 1'b0, 32'h100, 128'h0, 16'h0, "read_pattern");
        checks++;
        if (o_data !== 128'h1117_1116_1115_1114_1113_1112_1111_1110) begin
            failures++; $display("FAIL read_pattern_const: got %h required 1117..1110", o_data);
        end
    endtask

    task automatic test_masked_write();
        logic [127:0] d = {$urandom, $urandom, $urandom, $urandom};
        run_line(1'b0, 1'b1, 32'h200, d, 16'hFFF0, "masked_write");
        run_line(1'b1, 1'b0, 32'h200, 128'h0, 16'h0, "masked_readback");
    endtask

    task automatic test_rd_wins();
        logic [127:0] d = {$urandom, $urandom, $urandom, $urandom};
        run_line(1'b1, 1'b1, 32'h100 + 32'($urandom_range(0, 15)), d, 16'($urandom), "rd_wins");
    endtask

    task automatic test_random();
        logic [127:0] d;
        logic [15:0] m;
        int sel;
        for (int n = 0; n < 24; n++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            sel = $urandom_range(0, 3);
            m = (sel == 0) ? 16'h0000 : (sel == 1) ? 16'hFFFF : 16'($urandom);
            if ($urandom_range(0, 1) == 1)
                run_line(1'b1, 1'b0, 32'($urandom_range(0, 63) * 16 + $urandom_range(0, 15)), d, m, "rand_read");
            else
                run_line(1'b0, 1'b1, 32'($urandom_range(0, 63) * 16 + $urandom_range(0, 15)), d, m, "rand_write");
        end
    endtask

    task automatic test_reset_abort();
        int n0;
        bit ok;
        wait_idle(3000, ok);
        n0 = line_cmds;
        i_addr = 32'h400; i_data = {$urandom, $urandom, $urandom, $urandom}; i_mask = 16'h0; i_wr_en = 1'b1;
        for (int i = 0; i < 2000 && line_cmds < n0 + 4; i++) begin
            @(posedge clk); #1;
            if (line_cmds > n0) i_wr_en = 1'b0;
        end
        checks++;
        if (line_cmds < n0 + 4) begin failures++; $display("FAIL abort_reach_beat3: got %0d beats, required 4", line_cmds - n0); end
        #2 rst_x = 1'b0;
        #1;
        i_wr_en = 1'b0;
        exp_odata = '0;
        checks++; if ({m_rd, m_wr, m_refresh} !== 3'b000) begin failures++; $display("FAIL abort_cmds: got %b required 000", {m_rd, m_wr, m_refresh}); end
        checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL abort_busy: got %0b required 0", o_busy); end
        checks++; if ({m_addr, m_din, m_wmask} !== '0) begin failures++; $display("FAIL abort_bus: got addr=%h din=%h required 0", m_addr, m_din); end
        checks++; if (o_data !== 128'h0) begin failures++; $display("FAIL abort_odata: got %h required 0", o_data); end
        repeat (3) @(posedge clk); #1;
        rst_x = 1'b1;
        run_line(1'b1, 1'b0, 32'h100, 128'h0, 16'h0, "after_abort");
    endtask

    task automatic test_refresh();
`ifdef DRAM_BRIDGE_REFRESH_EN
        @(posedge clk); #1;
        rst_x = 1'b0;
        exp_odata = '0;
        @(posedge clk); #1;
        rst_x = 1'b1;
        repeat (RC - 1) @(posedge clk);
        #1;
        run_line(1'b1, 1'b0, 32'h100, 128'h0, 16'h0, "refresh_first");
        checks++;
        if (last_rf != 1) begin failures++; $display("FAIL refresh_first_order: got %0d leading refreshes, required 1", last_rf); end
`else
        checks++;
        if (rf_total != 0) begin failures++; $display("FAIL refresh_disabled: got %0d m_refresh pulses, required 0", rf_total); end
`endif
    endtask

    initial begin
        test_reset();
        test_init_gate();
        test_read_pattern();
        test_masked_write();
        test_rd_wins();
        test_random();
        test_reset_abort();
        test_refresh();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
